// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream master.
// Beat layout and FSM encoding used by the FIFO and the master.
package axis_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } axis_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } axis_mst_state_t;

endpackage

// File: rtl/axis_fifo.sv
// First-word-fall-through beat FIFO.
// dout_o always shows mem[rd_ptr]; it is only meaningful when not empty.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  axis_beat_t din_i,
    output axis_beat_t dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [AW:0] count_o
);

    axis_beat_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_master.sv
// Store-and-forward AXI-Stream master: buffers bytes and only
// releases a packet onto m_axis_* once its last byte is stored.
module axis_master #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     m_axis_aclk,
    input  logic                     m_axis_arstn,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_last,
    output logic                     wr_full,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     overflow,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    import axis_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]      rst_sync_q;
    logic            rst_n;

    axis_beat_t      din;
    axis_beat_t      head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;

    logic            push;
    logic            pop;
    logic            pkt_inc;
    logic            pkt_dec;

    axis_mst_state_t state_q;
    logic            tvalid_q;
    logic [CW-1:0]   pkt_q, pkt_d;
    logic            ovf_q, ovf_d;

    // Assert immediately, release two edges after m_axis_arstn rises.
    always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
        if (!m_axis_arstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign din.data = wr_data;
    assign din.last = wr_last;

    assign push    = wr_en && !fifo_full;
    assign pop     = tvalid_q && m_axis_tready && !fifo_empty;
    assign pkt_inc = push && wr_last;
    assign pkt_dec = pop && head.last;

    axis_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (m_axis_aclk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        pkt_d = pkt_q;
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_d = pkt_q + CW'(1);
            2'b01:   pkt_d = pkt_q - CW'(1);
            default: pkt_d = pkt_q;
        endcase
    end

    assign ovf_d = ovf_q | (wr_en && fifo_full);

    always_ff @(posedge m_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pkt_q <= pkt_d;
            ovf_q <= ovf_d;
        end
    end

    // Stay in SEND across packet boundaries while more complete packets wait.
    always_ff @(posedge m_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pkt_q != '0) begin
                        state_q  <= SEND;
                        tvalid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (pkt_dec && (pkt_q == CW'(1)) && !pkt_inc) begin
                        state_q  <= IDLE;
                        tvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_full       = fifo_count[AW];
    assign pkt_count     = pkt_q;
    assign overflow      = ovf_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tvalid_q ? head.data : '0;
    assign m_axis_tlast  = tvalid_q & head.last;

endmodule
